// File: rtl/udp_port_router.sv
// RX-side UDP demultiplexer: routes one frame at a time to the channel whose cfg_port matches the destination port.
// Optional frame/drop counters are compiled in when UDP_PORT_ROUTER_STATS_EN is defined.
module udp_port_router #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CHANNELS   = 4,
    parameter int STAT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [16*CHANNELS-1:0]     cfg_port,
    input  logic [CHANNELS-1:0]        cfg_enable,
    input  logic                       s_udp_hdr_valid,
    output logic                       s_udp_hdr_ready,
    input  logic [31:0]                s_udp_ip_source_ip,
    input  logic [15:0]                s_udp_source_port,
    input  logic [15:0]                s_udp_dest_port,
    input  logic [15:0]                s_udp_length,
    input  logic [DATA_WIDTH-1:0]      s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_udp_payload_axis_tkeep,
    input  logic                       s_udp_payload_axis_tvalid,
    output logic                       s_udp_payload_axis_tready,
    input  logic                       s_udp_payload_axis_tlast,
    input  logic                       s_udp_payload_axis_tuser,
    output logic [CHANNELS-1:0]        m_udp_hdr_valid,
    input  logic [CHANNELS-1:0]        m_udp_hdr_ready,
    output logic [31:0]                m_udp_ip_source_ip,
    output logic [15:0]                m_udp_source_port,
    output logic [15:0]                m_udp_dest_port,
    output logic [15:0]                m_udp_length,
    output logic [DATA_WIDTH-1:0]      m_udp_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_udp_payload_axis_tkeep,
    output logic [CHANNELS-1:0]        m_udp_payload_axis_tvalid,
    input  logic [CHANNELS-1:0]        m_udp_payload_axis_tready,
    output logic                       m_udp_payload_axis_tlast,
    output logic                       m_udp_payload_axis_tuser,
    output logic                       drop_pulse
`ifdef UDP_PORT_ROUTER_STATS_EN
    ,
    output logic [STAT_WIDTH*CHANNELS-1:0] stat_frames,
    output logic [STAT_WIDTH-1:0]          stat_drops
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t              state;
    logic [CHANNELS-1:0] sel_oh;
    logic [CHANNELS-1:0] match_oh;
    logic                tlast_beat;

    if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0 || KEEP_WIDTH != DATA_WIDTH / 8 ||
        CHANNELS < 1 || CHANNELS > 16 || STAT_WIDTH < 1) begin : g_bad_params
        $error("udp_port_router: illegal parameter combination");
    end

    // Descending scan so the lowest matching enabled channel is written last and wins.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        match_oh = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cfg_enable[i] && cfg_port[16*i +: 16] == s_udp_dest_port)
                match_oh = CHANNELS'(1) << i;
        end
    end

    always_comb begin
        m_udp_payload_axis_tvalid = '0;
        s_udp_payload_axis_tready = 1'b0;
        case (state)
            PAYLOAD: begin
                m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid ? sel_oh : '0;
                s_udp_payload_axis_tready = |(m_udp_payload_axis_tready & sel_oh);
            end
            DROP:    s_udp_payload_axis_tready = 1'b1;
            default: ;
        endcase
    end

    assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
    assign m_udp_payload_axis_tkeep = s_udp_payload_axis_tkeep;
    assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
    assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;

    assign tlast_beat = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready &&
                        s_udp_payload_axis_tlast;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            s_udp_hdr_ready    <= 1'b0;
            m_udp_hdr_valid    <= '0;
            drop_pulse         <= 1'b0;
            sel_oh             <= '0;
            m_udp_ip_source_ip <= '0;
            m_udp_source_port  <= '0;
            m_udp_dest_port    <= '0;
            m_udp_length       <= '0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    s_udp_hdr_ready <= 1'b1;
                    if (s_udp_hdr_valid && s_udp_hdr_ready) begin
                        s_udp_hdr_ready    <= 1'b0;
                        m_udp_ip_source_ip <= s_udp_ip_source_ip;
                        m_udp_source_port  <= s_udp_source_port;
                        m_udp_dest_port    <= s_udp_dest_port;
                        m_udp_length       <= s_udp_length;
                        sel_oh             <= match_oh;
                        if (|match_oh) begin
                            state           <= HDR;
                            m_udp_hdr_valid <= match_oh;
                        end else begin
                            state      <= DROP;
                            drop_pulse <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (|(m_udp_hdr_valid & m_udp_hdr_ready)) begin
                        m_udp_hdr_valid <= '0;
                        state           <= PAYLOAD;
                    end
                end
                PAYLOAD, DROP: begin
                    // Header ready rises together with the IDLE return, i.e. the cycle after tlast.
                    if (tlast_beat) begin
                        state           <= IDLE;
                        s_udp_hdr_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_PORT_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            if (drop_pulse)
                stat_drops <= stat_drops + STAT_WIDTH'(1);
            if (state == PAYLOAD && tlast_beat) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (sel_oh[i])
                        stat_frames[STAT_WIDTH*i +: STAT_WIDTH] <=
                            stat_frames[STAT_WIDTH*i +: STAT_WIDTH] + STAT_WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule
